button_debouncer: RTL and testbench

//  Conditions raw push-button inputs (board KEY pins) before they reach the Avalon PIO input slave.
//  Per button:
//   - 2-FF synchroniser, polarity normalisation, counter-based debounce FSM.
//   - btn_level is a clean level that drives the PIO in_port.
//   - btn_press / btn_release are one-cycle edge pulses for local logic (e.g. counter enable).

---
 rtl/btn_pkg.sv | 14 +
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/button_debouncer.sv | 40 ++++
 tb/tb_button_debouncer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioning block.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-FF synchroniser, polarity normalisation and counter-based debounce FSM.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic             RAW_REL = 1'(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level, r_press, r_release;
  logic             w_p;

  // Sync flops idle at the released pin level so reset exit never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= RAW_REL;
      r_sync2 <= RAW_REL;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = r_sync2 ^ RAW_REL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        RELEASED: if (w_p) begin
          r_state <= WAIT_PRESS;
          r_cnt   <= '0;
        end
        WAIT_PRESS: begin
          if (!w_p) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= PRESSED;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: if (!w_p) begin
          r_state <= WAIT_RELEASE;
          r_cnt   <= '0;
        end
        WAIT_RELEASE: begin
          if (w_p) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= RELEASED;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BTN raw key pins into clean levels plus press/release pulses for the PIO.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("button_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a run-length reference model checked every cycle.
module tb_button_debouncer;

  localparam int N   = 2;
  localparam int D   = 4;
  localparam int CW  = 4;
  localparam bit AL  = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_LOW(int'(AL))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the accepted level flips once the normalised sample seen by the
  // debouncer has disagreed with it for D+1 consecutive edges; samples reach the
  // debouncer two edges after the pins are sampled.
  logic [N-1:0] rq[$];
  logic [N-1:0] pq[$];
  logic [N-1:0] m_lvl = '0, m_prs = '0, m_rls = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        rq.delete(); pq.delete();
        m_lvl = '0; m_prs = '0; m_rls = '0;
      end else begin
        rq.push_back(btn_raw);
        if (rq.size() > 3) void'(rq.pop_front());
        if (rq.size() >= 3) pq.push_back(rq[rq.size()-3] ^ {N{AL}});
        else                pq.push_back('0);
        if (pq.size() > D + 1) void'(pq.pop_front());
        m_prs = '0; m_rls = '0;
        for (int c = 0; c < N; c++) begin
          bit run;
          run = (pq.size() == D + 1);
          for (int k = 0; k < pq.size(); k++)
            if (pq[k][c] == m_lvl[c]) run = 1'b0;
          if (run) begin
            m_lvl[c] = ~m_lvl[c];
            if (m_lvl[c]) m_prs[c] = 1'b1; else m_rls[c] = 1'b1;
          end
        end
      end
      #1;
      chk("model_level",   btn_level,   m_lvl);
      chk("model_press",   btn_press,   m_prs);
      chk("model_release", btn_release, m_rls);
    end
  end

  task automatic edge_chk(input string name, input logic [N-1:0] lvl,
                          input logic [N-1:0] prs, input logic [N-1:0] rls);
    @(posedge clk); #2;
    chk({name, "_level"},   btn_level,   lvl);
    chk({name, "_press"},   btn_press,   prs);
    chk({name, "_release"}, btn_release, rls);
  endtask

  task automatic hold(input int n, input string name, input logic [N-1:0] lvl);
    for (int i = 0; i < n; i++) edge_chk(name, lvl, '0, '0);
  endtask

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    btn_raw = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    btn_raw = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    chk("t1_reset_level", btn_level, 2'b00);
    @(negedge clk) reset = 1'b0;
    hold(20, "t1_idle", 2'b00);

    // single press on channel 0
    drive(2'b10);
    hold(6, "t2_wait", 2'b00);
    edge_chk("t2_press", 2'b01, 2'b01, 2'b00);
    edge_chk("t2_after", 2'b01, 2'b00, 2'b00);
    hold(3, "t2_hold", 2'b01);

    // release with a 2-cycle glitch that must restart the count
    drive(2'b11);
    hold(3, "t4_pre", 2'b01);
    drive(2'b10);
    hold(2, "t4_glitch", 2'b01);
    drive(2'b11);
    hold(6, "t4_wait", 2'b01);
    edge_chk("t4_release", 2'b00, 2'b00, 2'b01);
    edge_chk("t4_after", 2'b00, 2'b00, 2'b00);

    // bouncing press: never stable long enough, then held
    for (int i = 0; i < 5; i++) begin
      drive(2'b10);
      hold(3, "t3_bounce_lo", 2'b00);
      drive(2'b11);
      hold(1, "t3_bounce_hi", 2'b00);
    end
    drive(2'b10);
    hold(6, "t3_wait", 2'b00);
    edge_chk("t3_press", 2'b01, 2'b01, 2'b00);
    drive(2'b11);
    hold(6, "t3_rel_wait", 2'b01);
    edge_chk("t3_release", 2'b00, 2'b00, 2'b01);

    // simultaneous press and release on both channels
    drive(2'b00);
    hold(6, "t5_wait", 2'b00);
    edge_chk("t5_press", 2'b11, 2'b11, 2'b00);
    edge_chk("t5_after", 2'b11, 2'b00, 2'b00);
    drive(2'b11);
    hold(6, "t5_rel_wait", 2'b11);
    edge_chk("t5_release", 2'b00, 2'b00, 2'b11);

    // reset during WAIT_PRESS with the button held
    drive(2'b10);
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("t6_rst_wait_level", btn_level, 2'b00);
    chk("t6_rst_wait_press", btn_press, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    hold(6, "t6_wait1", 2'b00);
    edge_chk("t6_press1", 2'b01, 2'b01, 2'b00);
    hold(2, "t6_hold1", 2'b01);

    // reset while PRESSED: level must drop asynchronously, no release pulse
    @(negedge clk) reset = 1'b1;
    #1;
    chk("t6_rst_pressed_level",   btn_level,   2'b00);
    chk("t6_rst_pressed_release", btn_release, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    hold(6, "t6_wait2", 2'b00);
    edge_chk("t6_press2", 2'b01, 2'b01, 2'b00);
    hold(3, "t6_hold2", 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
